// File: rtl/ternary_result_drain.sv
// Snapshots the accumulator vector on frame completion and drains it as one
// AXI4-Stream packet: a header beat followed by one beat per lane.
module ternary_result_drain #(
    parameter int LANES     = 15,
    parameter int ACC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       capture,
    input  logic [LANES*ACC_WIDTH-1:0] vector_results,
    output logic [ACC_WIDTH-1:0]       m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       clear_overrun,
    output logic [15:0]                frame_seq,
    output logic [1:0]                 dbg_state
);

    // Stream handshake: a beat transfers on a rising edge where tvalid and
    // tready are both high; tdata/tlast hold and tvalid stays up until then.

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;

    localparam int              LIDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);
    localparam logic [LIDX_W-1:0] ONE_LANE  = LIDX_W'(1);
    localparam logic [7:0]      LANES_B   = 8'(LANES);

    logic [1:0]           state_q, state_d;
    logic [LIDX_W-1:0]    lane_idx_q, lane_idx_d;
    logic [ACC_WIDTH-1:0] active_q [LANES];
    logic [ACC_WIDTH-1:0] active_d [LANES];
    logic [ACC_WIDTH-1:0] pending_q [LANES];
    logic [ACC_WIDTH-1:0] pending_d [LANES];
    logic [ACC_WIDTH-1:0] vr_lane [LANES];
    logic [15:0]          active_seq_q, active_seq_d;
    logic [15:0]          pending_seq_q, pending_seq_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [15:0]          frame_seq_q, frame_seq_d;
    logic                 overrun_q, overrun_d;
    logic [ACC_WIDTH-1:0] tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 busy_q, busy_d;

    logic                 hs;
    logic                 last_hs;
    logic                 drop;
    logic [15:0]          seq_inc;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            vr_lane[k] = vector_results[k*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    always_comb begin
        state_d         = state_q;
        lane_idx_d      = lane_idx_q;
        active_d        = active_q;
        active_seq_d    = active_seq_q;
        pending_d       = pending_q;
        pending_seq_d   = pending_seq_q;
        pending_valid_d = pending_valid_q;
        frame_seq_d     = frame_seq_q;
        drop            = 1'b0;
        seq_inc         = frame_seq_q + 16'd1;
        hs              = tvalid_q & m_axis_tready;
        last_hs         = hs && (state_q == S_DATA) && (lane_idx_q == LAST_LANE);

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    active_d     = vr_lane;
                    active_seq_d = seq_inc;
                    frame_seq_d  = seq_inc;
                    state_d      = S_HEADER;
                end
            end
            S_HEADER: begin
                if (hs) begin
                    state_d    = S_DATA;
                    lane_idx_d = '0;
                end
            end
            S_DATA: begin
                if (hs && !last_hs) begin
                    lane_idx_d = lane_idx_q + ONE_LANE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Final beat frees a buffer, so a coincident capture is never dropped.
        if (last_hs) begin
            lane_idx_d = '0;
            if (pending_valid_q) begin
                active_d     = pending_q;
                active_seq_d = pending_seq_q;
                state_d      = S_HEADER;
                if (capture) begin
                    pending_d     = vr_lane;
                    pending_seq_d = seq_inc;
                    frame_seq_d   = seq_inc;
                end else begin
                    pending_valid_d = 1'b0;
                end
            end else if (capture) begin
                active_d     = vr_lane;
                active_seq_d = seq_inc;
                frame_seq_d  = seq_inc;
                state_d      = S_HEADER;
            end else begin
                state_d = S_IDLE;
            end
        end else if (capture && (state_q != S_IDLE)) begin
            if (!pending_valid_q) begin
                pending_d       = vr_lane;
                pending_seq_d   = seq_inc;
                pending_valid_d = 1'b1;
                frame_seq_d     = seq_inc;
            end else begin
                drop = 1'b1;
            end
        end

        overrun_d = drop | (overrun_q & ~clear_overrun);

        // Outputs are registered from next-state values so every port is a flop.
        tvalid_d = (state_d != S_IDLE);
        tlast_d  = (state_d == S_DATA) && (lane_idx_d == LAST_LANE);
        busy_d   = (state_d != S_IDLE) | pending_valid_d;
        if (state_d == S_HEADER) begin
            tdata_d = {active_seq_d, LANES_B, 8'hA5};
        end else if (state_d == S_DATA) begin
            tdata_d = active_d[lane_idx_d];
        end else begin
            tdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            lane_idx_q      <= '0;
            pending_valid_q <= 1'b0;
            frame_seq_q     <= '0;
            overrun_q       <= 1'b0;
            tdata_q         <= '0;
            tvalid_q        <= 1'b0;
            tlast_q         <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            lane_idx_q      <= lane_idx_d;
            pending_valid_q <= pending_valid_d;
            frame_seq_q     <= frame_seq_d;
            overrun_q       <= overrun_d;
            tdata_q         <= tdata_d;
            tvalid_q        <= tvalid_d;
            tlast_q         <= tlast_d;
            busy_q          <= busy_d;
        end
    end

    // Buffer contents are only meaningful behind state/pending_valid.
    always_ff @(posedge clk) begin
        active_q      <= active_d;
        pending_q     <= pending_d;
        active_seq_q  <= active_seq_d;
        pending_seq_q <= pending_seq_d;
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign frame_seq     = frame_seq_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ternary_result_drain.sv
// Directed bench for ternary_result_drain: expected beats are queued per
// packet and a negedge monitor compares every handshake against them.
module tb_ternary_result_drain;

    localparam int LANES = 15;
    localparam int W     = 32;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 capture;
    logic [LANES*W-1:0]   vector_results;
    logic [W-1:0]         m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 busy;
    logic                 overrun;
    logic                 clear_overrun;
    logic [15:0]          frame_seq;
    logic [1:0]           dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_last_q[$];

    int           ready_mode = 0;
    int           ready_cnt  = 0;
    bit           mon_en     = 1'b0;
    bit           pkt_started = 1'b0;
    int           gap_cnt    = 0;
    int           beats_seen = 0;
    bit           hold_pending = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_last;

    ternary_result_drain #(.LANES(LANES), .ACC_WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .capture        (capture),
        .vector_results (vector_results),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun),
        .frame_seq      (frame_seq),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        capture = 1'b0;
        clear_overrun = 1'b0;
        step(3);
        exp_q.delete();
        exp_last_q.delete();
        hold_pending = 1'b0;
        pkt_started  = 1'b0;
        gap_cnt      = 0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [LANES*W-1:0] make_vec(input int off);
        logic [LANES*W-1:0] v;
        for (int k = 0; k < LANES; k++) begin
            v[k*W +: W] = 32'(k) * 32'h1111_1111 + 32'(off);
        end
        return v;
    endfunction

    task automatic push_pkt(input logic [15:0] seq, input int off);
        exp_q.push_back({seq, 8'h0F, 8'hA5});
        exp_last_q.push_back(1'b0);
        for (int k = 0; k < LANES; k++) begin
            exp_q.push_back(32'(k) * 32'h1111_1111 + 32'(off));
            exp_last_q.push_back(k == LANES - 1);
        end
    endtask

    task automatic capture_pulse(input int off);
        capture        = 1'b1;
        vector_results = make_vec(off);
        step(1);
        capture        = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            step(1);
            cyc++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // tready: 0 = high, 1 = low, 2 = random, 3 = 1,0,0,1 then random
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'b0;
            2: m_axis_tready = 1'($urandom_range(0, 1));
            default: begin
                case (ready_cnt)
                    0, 3: m_axis_tready = 1'b1;
                    1, 2: m_axis_tready = 1'b0;
                    default: m_axis_tready = 1'($urandom_range(0, 1));
                endcase
                ready_cnt++;
            end
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (hold_pending) begin
                check("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
                check("hold_data", m_axis_tdata, hold_data);
                check("hold_last", {31'b0, m_axis_tlast}, {31'b0, hold_last});
            end
            hold_pending = m_axis_tvalid && !m_axis_tready;
            hold_data    = m_axis_tdata;
            hold_last    = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("beat_data", m_axis_tdata, exp_q.pop_front());
                    check("beat_last", {31'b0, m_axis_tlast}, {31'b0, exp_last_q.pop_front()});
                end
                beats_seen++;
                pkt_started = 1'b1;
            end else if (!m_axis_tvalid && pkt_started && exp_q.size() != 0) begin
                gap_cnt++;
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        int b0;
        m_axis_tready  = 1'b1;
        vector_results = '0;
        do_reset();

        // reset state
        check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_seq", {16'b0, frame_seq}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);

        // single frame, tready high, lane k = k*0x11111111 + 1
        ready_mode = 0;
        push_pkt(16'd1, 1);
        capture_pulse(1);
        check("t1_latency", {31'b0, m_axis_tvalid}, 32'd1);
        check("t1_header", m_axis_tdata, 32'h0001_0FA5);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_seq", {16'b0, frame_seq}, 32'd1);
        wait_drain(100);
        check("t1_idle_valid", {31'b0, m_axis_tvalid}, 32'd0);
        check("t1_idle_busy", {31'b0, busy}, 32'd0);

        // backpressure: exactly 16 handshakes with values held while stalled
        do_reset();
        ready_cnt  = 0;
        ready_mode = 3;
        b0 = beats_seen;
        push_pkt(16'd1, 5);
        capture_pulse(5);
        wait_drain(400);
        step(4);
        check("t2_beats", 32'(beats_seen - b0), 32'd16);
        check("t2_idle_valid", {31'b0, m_axis_tvalid}, 32'd0);

        // two captures three cycles apart: back-to-back packets
        do_reset();
        ready_mode = 0;
        push_pkt(16'd1, 7);
        push_pkt(16'd2, 9);
        capture_pulse(7);
        step(2);
        capture_pulse(9);
        check("t3_seq", {16'b0, frame_seq}, 32'd2);
        wait_drain(100);
        check("t3_gap", 32'(gap_cnt), 32'd0);
        check("t3_overrun", {31'b0, overrun}, 32'd0);

        // drops while stalled on beat 2, then clear / clear-vs-drop
        do_reset();
        ready_mode = 0;
        push_pkt(16'd1, 3);
        push_pkt(16'd2, 4);
        capture_pulse(3);
        step(1);
        ready_mode = 1;
        step(1);
        capture_pulse(4);
        capture_pulse(6);
        check("t4_overrun_set", {31'b0, overrun}, 32'd1);
        check("t4_seq", {16'b0, frame_seq}, 32'd2);
        step(2);
        check("t4_overrun_sticky", {31'b0, overrun}, 32'd1);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        check("t4_overrun_clr", {31'b0, overrun}, 32'd0);
        clear_overrun = 1'b1;
        capture_pulse(8);
        clear_overrun = 1'b0;
        check("t4_set_wins", {31'b0, overrun}, 32'd1);
        check("t4_seq_hold", {16'b0, frame_seq}, 32'd2);
        ready_mode = 0;
        wait_drain(100);
        step(5);
        check("t4_no_third", {31'b0, m_axis_tvalid}, 32'd0);

        // capture on final handshake with pending full
        do_reset();
        ready_mode = 0;
        push_pkt(16'd1, 2);
        push_pkt(16'd2, 12);
        push_pkt(16'd3, 22);
        capture_pulse(2);
        capture_pulse(12);
        step(14);
        capture_pulse(22);
        check("t5_seq", {16'b0, frame_seq}, 32'd3);
        check("t5_busy", {31'b0, busy}, 32'd1);
        wait_drain(200);
        check("t5_gap", 32'(gap_cnt), 32'd0);
        check("t5_overrun", {31'b0, overrun}, 32'd0);

        // capture on final handshake with pending empty
        do_reset();
        ready_mode = 0;
        push_pkt(16'd1, 30);
        push_pkt(16'd2, 31);
        capture_pulse(30);
        step(15);
        capture_pulse(31);
        wait_drain(100);
        check("t6_gap", 32'(gap_cnt), 32'd0);
        check("t6_overrun", {31'b0, overrun}, 32'd0);

        // reset in the middle of beat 7
        do_reset();
        ready_mode = 0;
        push_pkt(16'd1, 1);
        capture_pulse(1);
        step(7);
        check("t7_mid_beat", m_axis_tdata, 32'h6666_6667);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        step(1);
        check("t7_rst_valid", {31'b0, m_axis_tvalid}, 32'd0);
        check("t7_rst_busy", {31'b0, busy}, 32'd0);
        check("t7_rst_seq", {16'b0, frame_seq}, 32'd0);
        reset_n = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        hold_pending = 1'b0;
        pkt_started  = 1'b0;
        mon_en = 1'b1;
        push_pkt(16'd1, 50);
        capture_pulse(50);
        check("t7_header", m_axis_tdata, 32'h0001_0FA5);
        wait_drain(100);
        step(2);
        check("t7_idle_valid", {31'b0, m_axis_tvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
